// File: rtl/imm_pkg.sv
// imm_pkg: shared immediate-format encodings and RV opcode constants.
//   imm_fmt_e  : 3-bit immediate format select / resolved format
//   OP_*/LOAD..: 7-bit major opcodes used by AUTO format resolution
package imm_pkg;

    typedef enum logic [2:0] {
        IMM_I    = 3'd0,
        IMM_S    = 3'd1,
        IMM_B    = 3'd2,
        IMM_U    = 3'd3,
        IMM_J    = 3'd4,
        IMM_Z    = 3'd5,
        IMM_SH   = 3'd6,
        IMM_AUTO = 3'd7
    } imm_fmt_e;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] LOAD      = 7'b0000011;
    localparam logic [6:0] JALR      = 7'b1100111;
    localparam logic [6:0] STORE     = 7'b0100011;
    localparam logic [6:0] BRANCH    = 7'b1100011;
    localparam logic [6:0] LUI       = 7'b0110111;
    localparam logic [6:0] AUIPC     = 7'b0010111;
    localparam logic [6:0] JAL       = 7'b1101111;
    localparam logic [6:0] SYSTEM    = 7'b1110011;
    localparam logic [6:0] OP        = 7'b0110011;
    localparam logic [6:0] OP_32     = 7'b0111011;
    localparam logic [6:0] OP_IMM_32 = 7'b0011011;

endpackage

// File: rtl/imm_gen_pipe_if.sv
// imm_gen_pipe_if: handshake bus of the immediate generator.
//   flush                      : drop buffered entries and same-cycle input
//   in_valid/in_ready          : instruction-side handshake (instin, imgsel)
//   out_valid/out_ready        : execute-side handshake (imout, out_fmt, out_illegal)
//   master = producer/consumer side (bench or pipeline), slave = generator
interface imm_gen_pipe_if #(parameter int XLEN = 32);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instin;
    logic [2:0]      imgsel;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] imout;
    logic [2:0]      out_fmt;
    logic            out_illegal;

    modport master (
        output flush, in_valid, instin, imgsel, out_ready,
        input  in_ready, out_valid, imout, out_fmt, out_illegal
    );

    modport slave (
        input  flush, in_valid, instin, imgsel, out_ready,
        output in_ready, out_valid, imout, out_fmt, out_illegal
    );
endinterface

// File: rtl/imm_decode.sv
// imm_decode: combinational immediate extraction and AUTO format resolution.
//   instin  : instruction word
//   imgsel  : requested format (IMM_AUTO resolves from the opcode)
//   imout   : XLEN-bit extended immediate
//   fmt     : resolved format (never IMM_AUTO)
//   illegal : no legal immediate for this word/format
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instin,
    input  logic [2:0]      imgsel,
    output logic [XLEN-1:0] imout,
    output imm_fmt_e        fmt,
    output logic            illegal
);

    logic [6:0]      op;
    logic            sh_f3;
    imm_fmt_e        rfmt;
    logic            zero;
    logic            bad;
    logic [XLEN-1:0] ext;

    assign op    = instin[6:0];
    // funct3 of 001 (SLLI) or 101 (SRLI/SRAI) both have [13:12] == 01
    assign sh_f3 = instin[13:12] == 2'b01;

    always_comb begin
        rfmt = imm_fmt_e'(imgsel);
        zero = 1'b0;
        bad  = 1'b0;
        if (imgsel == IMM_AUTO) begin
            rfmt = IMM_I;
            case (op)
                OP_IMM:        rfmt = sh_f3 ? IMM_SH : IMM_I;
                LOAD, JALR:    rfmt = IMM_I;
                STORE:         rfmt = IMM_S;
                BRANCH:        rfmt = IMM_B;
                LUI, AUIPC:    rfmt = IMM_U;
                JAL:           rfmt = IMM_J;
                SYSTEM:        rfmt = instin[14] ? IMM_Z : IMM_I;
                OP, OP_32:     zero = 1'b1;
                OP_IMM_32: begin
                    rfmt = (XLEN == 64 && sh_f3) ? IMM_SH : IMM_I;
                    bad  = XLEN != 64;
                end
                default:       bad = 1'b1;
            endcase
        end
    end

    // signed size casts replicate instin[31] up to XLEN
    always_comb begin
        case (rfmt)
            IMM_I:   ext = XLEN'($signed(instin[31:20]));
            IMM_S:   ext = XLEN'($signed({instin[31:25], instin[11:7]}));
            IMM_B:   ext = XLEN'($signed({instin[31], instin[7], instin[30:25], instin[11:8], 1'b0}));
            IMM_U:   ext = XLEN'($signed({instin[31:12], 12'b0}));
            IMM_J:   ext = XLEN'($signed({instin[31], instin[19:12], instin[20], instin[30:21], 1'b0}));
            IMM_Z:   ext = XLEN'(instin[19:15]);
            IMM_SH:  ext = XLEN == 64 ? XLEN'(instin[25:20]) : XLEN'(instin[24:20]);
            default: ext = '0;
        endcase
    end

    assign imout   = (zero || bad) ? '0 : ext;
    assign fmt     = bad ? IMM_I : rfmt;
    // a 6-bit shamt does not exist on a 32-bit datapath
    assign illegal = bad || (rfmt == IMM_SH && XLEN == 32 && instin[25]);

endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered immediate generator with a 2-entry output FIFO.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : imm_gen_pipe_if slave (flush, in_* handshake, out_* handshake)
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    imm_gen_pipe_if.slave bus
);

    logic [XLEN-1:0] dec_imm;
    imm_fmt_e        dec_fmt;
    logic            dec_ill;

    logic [XLEN-1:0] imm_q [2];
    imm_fmt_e        fmt_q [2];
    logic [1:0]      ill_q;
    logic            wp;
    logic            rp;
    logic [1:0]      cnt;
    logic            push;
    logic            pop;

    imm_decode #(.XLEN(XLEN)) u_dec (
        .instin  (bus.instin),
        .imgsel  (bus.imgsel),
        .imout   (dec_imm),
        .fmt     (dec_fmt),
        .illegal (dec_ill)
    );

    // readiness comes from the registered count only, never from out_ready
    assign bus.in_ready    = cnt != 2'd2;
    assign bus.out_valid   = cnt != 2'd0;
    assign bus.imout       = imm_q[rp];
    assign bus.out_fmt     = fmt_q[rp];
    assign bus.out_illegal = ill_q[rp];

    assign push = bus.in_valid && bus.in_ready && !bus.flush;
    assign pop  = bus.out_valid && bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imm_q <= '{default: '0};
            fmt_q <= '{default: IMM_I};
            ill_q <= '0;
            wp    <= 1'b0;
            rp    <= 1'b0;
            cnt   <= '0;
        end else if (bus.flush) begin
            wp  <= 1'b0;
            rp  <= 1'b0;
            cnt <= '0;
        end else begin
            if (push) begin
                imm_q[wp] <= dec_imm;
                fmt_q[wp] <= dec_fmt;
                ill_q[wp] <= dec_ill;
                wp        <= ~wp;
            end
            if (pop) rp <= ~rp;
            cnt <= cnt + 2'(push) - 2'(pop);
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: directed self-checking bench for imm_gen_pipe at XLEN 32 and 64.
module tb_imm_gen_pipe;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    imm_gen_pipe_if #(.XLEN(32)) i32 ();
    imm_gen_pipe_if #(.XLEN(64)) i64 ();

    imm_gen_pipe #(.XLEN(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(i32));
    imm_gen_pipe #(.XLEN(64)) dut64 (.clk(clk), .rst_n(rst_n), .bus(i64));

    // head must stay stable across any edge where it was valid and not taken
    logic        hold = 1'b0;
    logic [31:0] hold_imm;
    logic [2:0]  hold_fmt;
    always @(posedge clk) begin
        if (!rst_n) begin
            hold <= 1'b0;
        end else begin
            if (hold) begin
                checks = checks + 1;
                if (!i32.out_valid || i32.imout !== hold_imm || i32.out_fmt !== hold_fmt) begin
                    failures = failures + 1;
                    $display("FAIL head_stable got v=%b imm=%h fmt=%0d exp v=1 imm=%h fmt=%0d",
                             i32.out_valid, i32.imout, i32.out_fmt, hold_imm, hold_fmt);
                end
            end
            hold     <= i32.out_valid && !i32.out_ready && !i32.flush;
            hold_imm <= i32.imout;
            hold_fmt <= i32.out_fmt;
        end
    end

    task automatic put32(input logic [31:0] w, input logic [2:0] s);
        i32.in_valid = 1'b1;
        i32.instin   = w;
        i32.imgsel   = s;
    endtask

    task automatic put64(input logic [31:0] w, input logic [2:0] s);
        i64.in_valid = 1'b1;
        i64.instin   = w;
        i64.imgsel   = s;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks = checks + 1;
        if (i32.out_valid !== 1'b0 || i32.in_ready !== 1'b1 || i32.imout !== 32'h0 || i32.out_fmt !== 3'd0 || i32.out_illegal !== 1'b0) begin
            failures = failures + 1;
            $display("FAIL reset32 got v=%b rdy=%b imm=%h fmt=%0d ill=%b exp v=0 rdy=1 imm=0 fmt=0 ill=0",
                     i32.out_valid, i32.in_ready, i32.imout, i32.out_fmt, i32.out_illegal);
        end
        checks = checks + 1;
        if (i64.out_valid !== 1'b0 || i64.in_ready !== 1'b1 || i64.imout !== 64'h0) begin
            failures = failures + 1;
            $display("FAIL reset64 got v=%b rdy=%b imm=%h exp v=0 rdy=1 imm=0", i64.out_valid, i64.in_ready, i64.imout);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks = checks + 1;
        if (i32.out_valid !== 1'b0 || i32.in_ready !== 1'b1) begin
            failures = failures + 1;
            $display("FAIL reset_release got v=%b rdy=%b exp v=0 rdy=1", i32.out_valid, i32.in_ready);
        end
    endtask

    task automatic test_auto32();
        logic [31:0] w  [5] = '{32'hFFF00093, 32'hFE000EE3, 32'h00B50533, 32'h00A00000, 32'hFE000F80};
        logic [2:0]  s  [5] = '{3'd7, 3'd7, 3'd7, 3'd4, 3'd1};
        logic [31:0] ei [5] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'h0, 32'h0000000A, 32'hFFFFFFFF};
        logic [2:0]  ef [5] = '{3'd0, 3'd2, 3'd0, 3'd4, 3'd1};
        for (int i = 0; i <= 5; i++) begin
            @(negedge clk);
            if (i == 0) begin
                checks = checks + 1;
                if (i32.out_valid !== 1'b0) begin
                    failures = failures + 1;
                    $display("FAIL auto32_latency got v=%b exp v=0", i32.out_valid);
                end
            end else begin
                checks = checks + 1;
                if (i32.out_valid !== 1'b1 || i32.imout !== ei[i-1] || i32.out_fmt !== ef[i-1] || i32.out_illegal !== 1'b0) begin
                    failures = failures + 1;
                    $display("FAIL auto32_%0d got v=%b imm=%h fmt=%0d ill=%b exp v=1 imm=%h fmt=%0d ill=0",
                             i-1, i32.out_valid, i32.imout, i32.out_fmt, i32.out_illegal, ei[i-1], ef[i-1]);
                end
            end
            if (i < 5) put32(w[i], s[i]);
            else i32.in_valid = 1'b0;
        end
        @(negedge clk);
        checks = checks + 1;
        if (i32.out_valid !== 1'b0) begin
            failures = failures + 1;
            $display("FAIL auto32_drain got v=%b exp v=0", i32.out_valid);
        end
    endtask

    task automatic test_illegal32();
        logic [31:0] w  [4] = '{32'h0000007F, 32'h02000000, 32'h0010909B, 32'h03F09093};
        logic [2:0]  s  [4] = '{3'd7, 3'd6, 3'd7, 3'd7};
        logic [2:0]  ef [4] = '{3'd0, 3'd6, 3'd0, 3'd6};
        logic        mi [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i <= 4; i++) begin
            @(negedge clk);
            if (i > 0) begin
                checks = checks + 1;
                if (i32.out_valid !== 1'b1 || i32.out_illegal !== 1'b1 || i32.out_fmt !== ef[i-1] || (mi[i-1] && i32.imout !== 32'h0)) begin
                    failures = failures + 1;
                    $display("FAIL illegal32_%0d got v=%b ill=%b fmt=%0d imm=%h exp v=1 ill=1 fmt=%0d imm=0",
                             i-1, i32.out_valid, i32.out_illegal, i32.out_fmt, i32.imout, ef[i-1]);
                end
            end
            if (i < 4) put32(w[i], s[i]);
            else i32.in_valid = 1'b0;
        end
    endtask

    task automatic test_auto64();
        logic [31:0] w  [6] = '{32'h800000B7, 32'h300FD073, 32'h03F09093, 32'h0010909B, 32'h0000007F, 32'hFE000EE3};
        logic [63:0] ei [6] = '{64'hFFFFFFFF80000000, 64'h1F, 64'd63, 64'd1, 64'h0, 64'hFFFFFFFFFFFFFFFC};
        logic [2:0]  ef [6] = '{3'd3, 3'd5, 3'd6, 3'd6, 3'd0, 3'd2};
        logic        el [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i <= 6; i++) begin
            @(negedge clk);
            if (i > 0) begin
                checks = checks + 1;
                if (i64.out_valid !== 1'b1 || i64.imout !== ei[i-1] || i64.out_fmt !== ef[i-1] || i64.out_illegal !== el[i-1]) begin
                    failures = failures + 1;
                    $display("FAIL auto64_%0d got v=%b imm=%h fmt=%0d ill=%b exp v=1 imm=%h fmt=%0d ill=%b",
                             i-1, i64.out_valid, i64.imout, i64.out_fmt, i64.out_illegal, ei[i-1], ef[i-1], el[i-1]);
                end
            end
            if (i < 6) put64(w[i], 3'd7);
            else i64.in_valid = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] w  [3] = '{32'h80000013, 32'h7FF00013, 32'hFFF00013};
        logic [2:0]  s  [3] = '{3'd0, 3'd0, 3'd3};
        logic [63:0] ei [3] = '{64'hFFFFFFFFFFFFF800, 64'h7FF, 64'hFFFFFFFFFFF00000};
        logic [2:0]  ef [3] = '{3'd0, 3'd0, 3'd3};
        for (int i = 0; i <= 3; i++) begin
            @(negedge clk);
            if (i > 0) begin
                checks = checks + 1;
                if (i64.out_valid !== 1'b1 || i64.in_ready !== 1'b1 || i64.imout !== ei[i-1] || i64.out_fmt !== ef[i-1]) begin
                    failures = failures + 1;
                    $display("FAIL b2b64_%0d got v=%b rdy=%b imm=%h fmt=%0d exp v=1 rdy=1 imm=%h fmt=%0d",
                             i-1, i64.out_valid, i64.in_ready, i64.imout, i64.out_fmt, ei[i-1], ef[i-1]);
                end
            end
            if (i < 3) put64(w[i], s[i]);
            else i64.in_valid = 1'b0;
        end
        @(negedge clk);
        checks = checks + 1;
        if (i64.out_valid !== 1'b0) begin
            failures = failures + 1;
            $display("FAIL b2b64_drain got v=%b exp v=0", i64.out_valid);
        end
    endtask

    task automatic test_backpressure();
        i32.out_ready = 1'b0;
        @(negedge clk);
        put32(32'h00100013, 3'd0);
        checks = checks + 1;
        if (i32.in_ready !== 1'b1) begin
            failures = failures + 1;
            $display("FAIL bp_ready_empty got rdy=%b exp rdy=1", i32.in_ready);
        end
        @(negedge clk);
        put32(32'h00200013, 3'd0);
        checks = checks + 1;
        if (i32.in_ready !== 1'b1 || i32.out_valid !== 1'b1 || i32.imout !== 32'd1) begin
            failures = failures + 1;
            $display("FAIL bp_one got rdy=%b v=%b imm=%h exp rdy=1 v=1 imm=1", i32.in_ready, i32.out_valid, i32.imout);
        end
        @(negedge clk);
        put32(32'h00300013, 3'd0);
        checks = checks + 1;
        if (i32.in_ready !== 1'b0) begin
            failures = failures + 1;
            $display("FAIL bp_full got rdy=%b exp rdy=0", i32.in_ready);
        end
        repeat (2) @(negedge clk);
        checks = checks + 1;
        if (i32.in_ready !== 1'b0 || i32.imout !== 32'd1) begin
            failures = failures + 1;
            $display("FAIL bp_hold got rdy=%b imm=%h exp rdy=0 imm=1", i32.in_ready, i32.imout);
        end
        i32.out_ready = 1'b1;
        checks = checks + 1;
        if (i32.in_ready !== 1'b0) begin
            failures = failures + 1;
            $display("FAIL bp_ready_ignores_out_ready got rdy=%b exp rdy=0", i32.in_ready);
        end
        @(negedge clk);
        checks = checks + 1;
        if (i32.in_ready !== 1'b1 || i32.out_valid !== 1'b1 || i32.imout !== 32'd2) begin
            failures = failures + 1;
            $display("FAIL bp_second got rdy=%b v=%b imm=%h exp rdy=1 v=1 imm=2", i32.in_ready, i32.out_valid, i32.imout);
        end
        @(negedge clk);
        i32.in_valid = 1'b0;
        checks = checks + 1;
        if (i32.out_valid !== 1'b1 || i32.imout !== 32'd3) begin
            failures = failures + 1;
            $display("FAIL bp_third got v=%b imm=%h exp v=1 imm=3", i32.out_valid, i32.imout);
        end
        @(negedge clk);
        checks = checks + 1;
        if (i32.out_valid !== 1'b0) begin
            failures = failures + 1;
            $display("FAIL bp_drain got v=%b exp v=0", i32.out_valid);
        end
    endtask

    task automatic test_flush();
        i32.out_ready = 1'b0;
        @(negedge clk);
        put32(32'h00400013, 3'd0);
        @(negedge clk);
        put32(32'h00500013, 3'd0);
        @(negedge clk);
        put32(32'h00600013, 3'd0);
        i32.flush = 1'b1;
        checks = checks + 1;
        if (i32.in_ready !== 1'b0 || i32.imout !== 32'd4) begin
            failures = failures + 1;
            $display("FAIL flush_prefull got rdy=%b imm=%h exp rdy=0 imm=4", i32.in_ready, i32.imout);
        end
        @(negedge clk);
        i32.flush = 1'b0;
        i32.in_valid = 1'b0;
        checks = checks + 1;
        if (i32.out_valid !== 1'b0 || i32.in_ready !== 1'b1) begin
            failures = failures + 1;
            $display("FAIL flush_full got v=%b rdy=%b exp v=0 rdy=1", i32.out_valid, i32.in_ready);
        end
        i32.out_ready = 1'b1;
        put32(32'h00700013, 3'd0);
        @(negedge clk);
        i32.in_valid = 1'b0;
        checks = checks + 1;
        if (i32.out_valid !== 1'b1 || i32.imout !== 32'd7) begin
            failures = failures + 1;
            $display("FAIL flush_next got v=%b imm=%h exp v=1 imm=7", i32.out_valid, i32.imout);
        end
        i32.out_ready = 1'b0;
        put32(32'h00800013, 3'd0);
        @(negedge clk);
        put32(32'h00900013, 3'd0);
        i32.flush = 1'b1;
        @(negedge clk);
        i32.flush = 1'b0;
        i32.in_valid = 1'b0;
        checks = checks + 1;
        if (i32.out_valid !== 1'b0 || i32.in_ready !== 1'b1) begin
            failures = failures + 1;
            $display("FAIL flush_push_drop got v=%b rdy=%b exp v=0 rdy=1", i32.out_valid, i32.in_ready);
        end
        i32.out_ready = 1'b1;
    endtask

    task automatic test_async_reset();
        i32.out_ready = 1'b0;
        @(negedge clk);
        put32(32'h02A00013, 3'd6);
        @(negedge clk);
        i32.in_valid = 1'b0;
        checks = checks + 1;
        if (i32.out_valid !== 1'b1 || i32.out_illegal !== 1'b1 || i32.imout !== 32'd10 || i32.out_fmt !== 3'd6) begin
            failures = failures + 1;
            $display("FAIL arst_pre got v=%b ill=%b imm=%h fmt=%0d exp v=1 ill=1 imm=a fmt=6",
                     i32.out_valid, i32.out_illegal, i32.imout, i32.out_fmt);
        end
        #2 rst_n = 1'b0;
        #1;
        checks = checks + 1;
        if (i32.out_valid !== 1'b0 || i32.out_illegal !== 1'b0 || i32.imout !== 32'h0 || i32.out_fmt !== 3'd0 || i32.in_ready !== 1'b1) begin
            failures = failures + 1;
            $display("FAIL arst_clear got v=%b ill=%b imm=%h fmt=%0d rdy=%b exp v=0 ill=0 imm=0 fmt=0 rdy=1",
                     i32.out_valid, i32.out_illegal, i32.imout, i32.out_fmt, i32.in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        i32.out_ready = 1'b1;
        @(negedge clk);
        checks = checks + 1;
        if (i32.out_valid !== 1'b0) begin
            failures = failures + 1;
            $display("FAIL arst_after got v=%b exp v=0", i32.out_valid);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        i32.flush = 1'b0; i32.in_valid = 1'b0; i32.instin = '0; i32.imgsel = '0; i32.out_ready = 1'b1;
        i64.flush = 1'b0; i64.in_valid = 1'b0; i64.instin = '0; i64.imgsel = '0; i64.out_ready = 1'b1;
        test_reset();
        test_auto32();
        test_illegal32();
        test_auto64();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_async_reset();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Parametrised, registered immediate generator for the decode stage. Extracts and sign/zero-extends the instruction immediate to XLEN bits for all base formats plus CSR zimm and shift amounts, or auto-selects the format from the opcode. A 2-entry output buffer with valid/ready handshakes on both sides decouples fetch from execute and supports pipeline flush.

## Interface
- XLEN, 32: datapath width; legal values are 32 and 64.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  drops all buffered entries and any same-cycle input
- in_valid  in  1  instin/imgsel valid
- in_ready  out  1  buffer can accept (count < 2)
- instin  in  32  instruction word
- imgsel  in  3  format: 0 I, 1 S, 2 B, 3 U, 4 J, 5 Z (CSR zimm), 6 SH (shamt), 7 AUTO
- out_valid  out  1  head entry valid
- out_ready  in  1  consumer accepts head
- imout  out  XLEN  extended immediate of head entry
- out_fmt  out  3  resolved format of head entry (0-6; never 7)
- out_illegal  out  1  head entry has no legal immediate

## Operation
- Extraction, with sign bit instin[31] replicated to XLEN:
  - I: [31:20]
  - S: {[31:25],[11:7]}
  - B: {[31],[7],[30:25],[11:8],0}
  - U: {[31:12],12'b0}, sign-extended above bit 31 when XLEN=64
  - J: {[31],[19:12],[20],[30:21],0}
- Z: zero-extended instin[19:15].
- SH: zero-extended [25:20] when XLEN=64, [24:20] when XLEN=32. XLEN=32 with instin[25]=1 sets illegal.
- AUTO resolves the format from opcode instin[6:0]:
  - 0010011: SH if funct3 is 001 or 101, else I
  - 0000011, 1100111: I
  - 0100011: S
  - 1100011: B
  - 0110111, 0010111: U
  - 1101111: J
  - 1110011: Z if instin[14]=1, else I
  - 0110011, 0111011: fmt I, imout 0, not illegal
  - 0011011 (XLEN=64 only): SH if funct3 is 001 or 101, else I
  - Any other opcode: imout 0, fmt 0, illegal=1
- Buffer:
  - 2-entry FIFO of {imout, fmt, illegal}.
  - Push on in_valid && in_ready.
  - Pop on out_valid && out_ready.
  - Push and pop in the same cycle keeps the count.
  - No combinational input-to-output path.
- Flush (synchronous): count and pointers go to 0; the same-cycle push is discarded.
- Reset: count 0, pointers 0, storage 0, out_valid 0, imout 0, out_fmt 0, out_illegal 0. in_ready is 1 while rst_n is low and after release.

## Timing
- Latency: 1 cycle from accepting edge to out_valid.
- Throughput: 1 per cycle while out_ready=1.
- in_ready = (count != 2), derived from registered count only; it does not depend on same-cycle out_ready.
  - Full with out_ready=1: in_ready stays 0 that cycle and returns to 1 the next cycle.
- Pointers wrap modulo 2.
- out_valid = (count != 0).
- Head data holds stable while out_valid && !out_ready (AXI-style rule); the bench asserts this.
- Reset asserted mid-transfer clears everything immediately. Entries are lost and no partial output is produced.

## Structure
- Shared package imm_pkg:
  - format encodings (IMM_I … IMM_AUTO)
  - opcode constants (OP_IMM, LOAD, JALR, STORE, BRANCH, LUI, AUIPC, JAL, SYSTEM, OP, OP_32, OP_IMM_32)
- Sub-module imm_decode (combinational, parameter XLEN): instin, imgsel → imout, fmt, illegal.
- imm_gen_pipe instantiates imm_decode and the 2-entry buffer.

## Test plan
- XLEN=32, AUTO:
  - 0xFFF00093 → imout 0xFFFFFFFF, fmt I, 1 cycle later.
  - 0xFE000EE3 → 0xFFFFFFFC, fmt B.
- XLEN=64, AUTO, 0x800000B7 → 0xFFFFFFFF80000000, fmt U. 0x300FD073 → 0x1F, fmt Z.
- Shift amount:
  - XLEN=64, AUTO, 0x03F09093 → imout 63, fmt SH, illegal 0.
  - Same word at XLEN=32 → illegal 1.
- Backpressure: out_ready=0, push 3 words.
  - in_ready drops after 2 accepts.
  - Head holds stable.
  - Release out_ready: outputs appear in order, no loss or duplication.
- Flush while full and in_valid=1: next cycle out_valid=0, in_ready=1, and the flushed-cycle word never appears.
- Reset and illegal cases:
  - rst_n low with 1 entry buffered, async mid-cycle: outputs 0 immediately.
  - Opcode 0x7F in AUTO → imout 0, illegal 1.
  - imgsel=6 with XLEN=32 and bit25=1 → illegal 1.
